// File: rtl/wb_pwm_nch.sv
// N-channel Wishbone PWM slave: prescaled shared timebase, per-channel duty/polarity/enable,
// shadowed period and duty that reload at period wrap, and a period-end interrupt.
module wb_pwm_nch #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PRESC_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_sel_i,
  output logic                wb_ack_o,
  output logic                intr,
  output logic [CHANNELS-1:0] pwm_o
);

  localparam logic [5:0] AdrCtrl   = 6'd0;
  localparam logic [5:0] AdrStatus = 6'd1;
  localparam logic [5:0] AdrPresc  = 6'd2;
  localparam logic [5:0] AdrPeriod = 6'd3;
  localparam logic [5:0] AdrPol    = 6'd4;
  localparam logic [5:0] AdrChen   = 6'd5;
  localparam logic [5:0] AdrDuty   = 6'd16;

  logic [5:0]          idx;
  logic                access;
  logic                wr;
  logic                en_rise;
  logic                clr_pend;
  logic                tick;
  logic                wrap;
  logic [31:0]         rdata;
  logic [CHANNELS-1:0] raw;

  logic                en;
  logic                irq_en;
  logic                pend;
  logic [PRESC_W-1:0]  presc;
  logic [PRESC_W-1:0]  pcnt;
  logic [CNT_W-1:0]    period;
  logic [CNT_W-1:0]    per_sh;
  logic [CNT_W-1:0]    cnt;
  logic [CHANNELS-1:0] pol;
  logic [CHANNELS-1:0] chen;
  logic [CNT_W-1:0]    duty    [CHANNELS];
  logic [CNT_W-1:0]    duty_sh [CHANNELS];

  // Byte lanes and undecoded address bits have no function.
  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i};

  assign idx      = wb_adr_i[7:2];
  assign access   = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr       = access & wb_we_i;
  assign en_rise  = wr && (idx == AdrCtrl) && wb_dat_i[0] && !en;
  assign clr_pend = wr && (idx == AdrStatus) && wb_dat_i[0];
  assign tick     = en && (pcnt == presc);
  assign wrap     = tick && (cnt == per_sh);

  always_comb begin
    rdata = '0;
    case (idx)
      AdrCtrl:   rdata[1:0] = {irq_en, en};
      AdrStatus: rdata[0] = pend;
      AdrPresc:  rdata[PRESC_W-1:0] = presc;
      AdrPeriod: rdata[CNT_W-1:0] = period;
      AdrPol:    rdata[CHANNELS-1:0] = pol;
      AdrChen:   rdata[CHANNELS-1:0] = chen;
      default:   ;
    endcase
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (idx == AdrDuty + 6'(i)) begin
        rdata[CNT_W-1:0] = duty[i];
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      raw[i] = (cnt < duty_sh[i]);
    end
  end

  // Bus interface and software-visible registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      en       <= 1'b0;
      irq_en   <= 1'b0;
      presc    <= '0;
      period   <= '0;
      pol      <= '0;
      chen     <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        duty[i] <= '0;
      end
    end else begin
      wb_ack_o <= access;
      wb_dat_o <= (access && !wb_we_i) ? rdata : 32'b0;
      if (wr) begin
        case (idx)
          AdrCtrl: begin
            en     <= wb_dat_i[0];
            irq_en <= wb_dat_i[1];
          end
          AdrPresc:  presc  <= wb_dat_i[PRESC_W-1:0];
          AdrPeriod: period <= wb_dat_i[CNT_W-1:0];
          AdrPol:    pol    <= wb_dat_i[CHANNELS-1:0];
          AdrChen:   chen   <= wb_dat_i[CHANNELS-1:0];
          default:   ;
        endcase
        for (int i = 0; i < int'(CHANNELS); i++) begin
          if (idx == AdrDuty + 6'(i)) begin
            duty[i] <= wb_dat_i[CNT_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      pcnt <= '0;
      cnt  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      cnt  <= wrap ? '0 : cnt + CNT_W'(1);
    end else begin
      pcnt <= pcnt + PRESC_W'(1);
    end
  end

  // Shadows also load on enable so the first period uses the freshly written values.
  always_ff @(posedge clk) begin
    if (reset) begin
      per_sh <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        duty_sh[i] <= '0;
      end
    end else if (wrap || en_rise) begin
      per_sh <= period;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        duty_sh[i] <= duty[i];
      end
    end
  end

  // A wrap in the same cycle as a clear keeps PEND set.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
      intr <= 1'b0;
    end else begin
      if (wrap) begin
        pend <= 1'b1;
      end else if (clr_pend) begin
        pend <= 1'b0;
      end
      intr <= pend & irq_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_o <= '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        pwm_o[i] <= (en && chen[i]) ? (raw[i] ^ pol[i]) : pol[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_pwm_nch.sv
// Directed bench for wb_pwm_nch: register map, PWM waveform, shadow reload, polarity,
// interrupt handling, prescaler and mid-run reset.
module tb_wb_pwm_nch;

  localparam int CH = 4;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_STATUS = 32'h04;
  localparam logic [31:0] A_PRESC  = 32'h08;
  localparam logic [31:0] A_PERIOD = 32'h0C;
  localparam logic [31:0] A_POL    = 32'h10;
  localparam logic [31:0] A_CHEN   = 32'h14;
  localparam logic [31:0] A_DUTY0  = 32'h40;
  localparam logic [31:0] A_DUTY1  = 32'h44;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   wb_adr_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_stb_i = 1'b0;
  logic          wb_cyc_i = 1'b0;
  logic          wb_we_i = 1'b0;
  logic [3:0]    wb_sel_i = 4'hF;
  logic          wb_ack_o;
  logic          intr;
  logic [CH-1:0] pwm_o;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  wb_pwm_nch #(.CHANNELS(CH), .CNT_W(16), .PRESC_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_ack_o (wb_ack_o),
    .intr     (intr),
    .pwm_o    (pwm_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Run-length monitor of pwm_o[0], sampled on the falling edge.
  logic mon_prev = 1'b0;
  int   mon_run = 0;
  int   hq[$];
  int   lq[$];
  always @(negedge clk) begin
    logic s;
    s = (pwm_o[0] === 1'b1);
    if (s == mon_prev) mon_run++;
    else begin
      if (mon_prev) hq.push_back(mon_run);
      else lq.push_back(mon_run);
      mon_prev = s;
      mon_run = 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          output logic [31:0] rdat, output int lat);
    bit got;
    @(negedge clk);
    wb_adr_i = adr; wb_dat_i = wdat; wb_we_i = we; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    got = 0; rdat = '0; lat = 0;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(posedge clk); #1;
      if (wb_ack_o === 1'b1) begin got = 1; rdat = wb_dat_o; lat = n; end
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL bus_timeout adr=%h: no ack within 8 cycles, required ack", adr);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] d; int l;
    wb_cycle(adr, 1'b1, dat, d, l);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    int l;
    wb_cycle(adr, 1'b0, 32'h0, dat, l);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] adrs [11];
    logic [31:0] d;
    int lat;
    adrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
             32'h40, 32'h44, 32'h48, 32'h4C, 32'h18};
    do_reset();
    checks++;
    if (pwm_o !== '0 || intr !== 1'b0) begin
      errors++; $display("FAIL reset_outputs pwm=%b intr=%b, required 0 0", pwm_o, intr);
    end
    foreach (adrs[i]) begin
      wb_cycle(adrs[i], 1'b0, 32'h0, d, lat);
      checks++;
      if (d !== 32'h0) begin
        errors++; $display("FAIL reset_read adr=%h got %h, required 0", adrs[i], d);
      end
      checks++;
      if (lat !== 1) begin
        errors++; $display("FAIL ack_latency adr=%h got %0d, required 1", adrs[i], lat);
      end
      @(posedge clk); #1;
      checks++;
      if (wb_ack_o !== 1'b0) begin
        errors++; $display("FAIL ack_width adr=%h ack still %b, required 0", adrs[i], wb_ack_o);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    wb_write(A_PERIOD, 32'hFFFF_0009); wb_read(A_PERIOD, d);
    checks++;
    if (d !== 32'h0000_0009) begin errors++; $display("FAIL period_trunc got %h, required 9", d); end
    wb_write(A_PRESC, 32'hABCD_1234); wb_read(A_PRESC, d);
    checks++;
    if (d !== 32'h0000_1234) begin errors++; $display("FAIL presc_trunc got %h, required 1234", d); end
    wb_write(A_POL, 32'hFF); wb_read(A_POL, d);
    checks++;
    if (d !== 32'h0000_000F) begin errors++; $display("FAIL pol_trunc got %h, required f", d); end
    wb_write(A_CTRL, 32'hFFFF_FFFC); wb_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ctrl_unused got %h, required 0", d); end
    wb_write(32'h4C, 32'h0001_2345); wb_read(32'h4C, d);
    checks++;
    if (d !== 32'h0000_2345) begin errors++; $display("FAIL duty3_rw got %h, required 2345", d); end
    wb_write(32'h50, 32'h5555); wb_read(32'h50, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL duty_oob got %h, required 0", d); end
  endtask

  task automatic test_basic_pwm();
    do_reset();
    wb_write(A_PRESC, 0); wb_write(A_PERIOD, 9); wb_write(A_DUTY0, 3); wb_write(A_CHEN, 1);
    wb_write(A_CTRL, 1);
    hq.delete(); lq.delete();
    repeat (35) @(posedge clk);
    #1;
    checks++;
    if (hq.size() < 3 || hq[0] != 3 || hq[1] != 3 || hq[2] != 3) begin
      errors++; $display("FAIL basic_high n=%0d first=%0d, required 3 runs of 3", hq.size(),
                         (hq.size() > 0) ? hq[0] : -1);
    end
    checks++;
    if (lq.size() < 3 || lq[1] != 7 || lq[2] != 7) begin
      errors++; $display("FAIL basic_low n=%0d second=%0d, required 7", lq.size(),
                         (lq.size() > 1) ? lq[1] : -1);
    end
  endtask

  task automatic test_shadow();
    int n0, ln, hn;
    bit seen;
    logic [31:0] d;
    n0 = lq.size(); seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (lq.size() > n0) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL shadow_sync no rising edge in 30 cycles, required one"); end
    ln = lq.size(); hn = hq.size();
    wb_write(A_DUTY0, 7);
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (hq.size() < hn + 2 || hq[hn] != 3 || hq[hn+1] != 7) begin
      errors++; $display("FAIL shadow_high cur=%0d next=%0d, required 3 then 7",
                         (hq.size() > hn) ? hq[hn] : -1, (hq.size() > hn + 1) ? hq[hn+1] : -1);
    end
    checks++;
    if (lq.size() < ln + 2 || lq[ln] != 7 || lq[ln+1] != 3) begin
      errors++; $display("FAIL shadow_low cur=%0d next=%0d, required 7 then 3",
                         (lq.size() > ln) ? lq[ln] : -1, (lq.size() > ln + 1) ? lq[ln+1] : -1);
    end
    wb_read(A_DUTY0, d);
    checks++;
    if (d !== 32'd7) begin errors++; $display("FAIL duty_readback got %h, required 7", d); end
  endtask

  task automatic test_extremes();
    int ones;
    do_reset();
    wb_write(A_PERIOD, 9); wb_write(A_DUTY1, 0); wb_write(A_CHEN, 3); wb_write(A_CTRL, 1);
    ones = 0;
    for (int i = 0; i < 25; i++) begin @(posedge clk); #1; if (pwm_o[1] === 1'b1) ones++; end
    checks++;
    if (ones != 0) begin errors++; $display("FAIL duty_zero ones=%0d, required 0", ones); end
    wb_write(A_DUTY1, 10);
    repeat (12) @(posedge clk);
    ones = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (pwm_o[1] === 1'b1) ones++; end
    checks++;
    if (ones != 20) begin errors++; $display("FAIL duty_over ones=%0d, required 20", ones); end
    wb_write(A_POL, 2);
    @(posedge clk);
    ones = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (pwm_o[1] === 1'b1) ones++; end
    checks++;
    if (ones != 0) begin errors++; $display("FAIL pol_invert ones=%0d, required 0", ones); end
    wb_write(A_CHEN, 1);
    @(posedge clk);
    ones = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (pwm_o[1] === 1'b1) ones++; end
    checks++;
    if (ones != 20) begin errors++; $display("FAIL disabled_idle ones=%0d, required 20", ones); end
  endtask

  task automatic test_irq();
    int en_edge, guard;
    logic [31:0] d;
    do_reset();
    wb_write(A_PERIOD, 9); wb_write(A_DUTY0, 3); wb_write(A_CHEN, 1);
    wb_write(A_CTRL, 3);
    en_edge = cyc_cnt;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (intr !== 1'b0) begin errors++; $display("FAIL intr_early got %b at wrap, required 0", intr); end
    @(posedge clk); #1;
    checks++;
    if (intr !== 1'b1) begin errors++; $display("FAIL intr_set got %b, required 1", intr); end
    wb_read(A_STATUS, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL pend_set got %h, required 1", d); end
    wb_write(A_STATUS, 1);
    @(posedge clk); #1;
    checks++;
    if (intr !== 1'b0) begin errors++; $display("FAIL intr_clear got %b, required 0", intr); end
    wb_read(A_STATUS, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL pend_clear got %h, required 0", d); end
    guard = 0;
    while (cyc_cnt < en_edge + 29 && guard < 100) begin @(posedge clk); #1; guard++; end
    checks++;
    if (cyc_cnt != en_edge + 29) begin
      errors++; $display("FAIL irq_align cycle=%0d, required %0d", cyc_cnt - en_edge, 29);
    end
    wb_write(A_STATUS, 1);
    wb_read(A_STATUS, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL pend_set_wins got %h, required 1", d); end
    checks++;
    if (intr !== 1'b1) begin errors++; $display("FAIL intr_kept got %b, required 1", intr); end
    wb_write(A_CTRL, 1);
    @(posedge clk); #1;
    checks++;
    if (intr !== 1'b0) begin errors++; $display("FAIL intr_mask got %b, required 0", intr); end
    wb_read(A_STATUS, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL pend_masked got %h, required 1", d); end
  endtask

  task automatic test_presc_reset();
    logic [31:0] adrs [7];
    logic [31:0] d;
    bit seen;
    adrs = '{A_CTRL, A_STATUS, A_PRESC, A_PERIOD, A_POL, A_CHEN, A_DUTY0};
    do_reset();
    wb_write(A_PRESC, 3); wb_write(A_PERIOD, 9); wb_write(A_DUTY0, 3);
    wb_write(A_CHEN, 1); wb_write(A_POL, 2); wb_write(A_CTRL, 3);
    hq.delete(); lq.delete();
    repeat (90) @(posedge clk);
    #1;
    checks++;
    if (hq.size() < 2 || hq[0] != 12 || hq[1] != 12) begin
      errors++; $display("FAIL presc_high first=%0d, required 12", (hq.size() > 0) ? hq[0] : -1);
    end
    checks++;
    if (lq.size() < 3 || lq[1] != 28 || lq[2] != 28) begin
      errors++; $display("FAIL presc_low second=%0d, required 28", (lq.size() > 1) ? lq[1] : -1);
    end
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (pwm_o[0] === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || pwm_o[1] !== 1'b1 || intr !== 1'b1) begin
      errors++; $display("FAIL pre_reset pwm=%b intr=%b, required pwm[1:0]=11 intr=1", pwm_o, intr);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pwm_o !== '0 || intr !== 1'b0 || wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      errors++; $display("FAIL mid_reset pwm=%b intr=%b ack=%b dat=%h, required all 0",
                         pwm_o, intr, wb_ack_o, wb_dat_o);
    end
    reset = 1'b0;
    foreach (adrs[i]) begin
      wb_read(adrs[i], d);
      checks++;
      if (d !== 32'h0) begin
        errors++; $display("FAIL post_reset_read adr=%h got %h, required 0", adrs[i], d);
      end
    end
    checks++;
    if (pwm_o !== '0) begin errors++; $display("FAIL post_reset_pwm got %b, required 0", pwm_o); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_basic_pwm();
    test_shadow();
    test_extremes();
    test_irq();
    test_presc_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
